rv32i_rf_wb_arbiter: RTL
========================

# rv32i_rf_wb_arbiter

Round-robin writeback arbiter that shares the integer register file's single write port among up to `NUM_REQ` writeback sources, such as the in-order ALU path, the load unit and the multiply/divide unit. A debug/CSR write port has absolute priority over all sources. The winning write is registered, so the register file sees `wen`/`rd`/`w_data` one cycle after the grant. Writes to x0 are accepted and dropped; they never assert `wen`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of writeback requesters (2..8).
- `CNT_W`, default 16: width of the saturating contention counter.

Ports:
- `CLK` in 1: single clock.
- `RST` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: requester i holds a write.
- `req_rd` in `NUM_REQ`x5: destination register per requester.
- `req_data` in `NUM_REQ`x32: write data per requester.
- `req_ready` out `NUM_REQ`: one-hot grant; the transfer happens when `req_valid[i] & req_ready[i]`.
- `dbg_wen` in 1: debug/CSR write request; single-cycle pulse, always accepted.
- `dbg_rd` in 5: debug write destination.
- `dbg_data` in 32: debug write data.
- `wen` out 1: register-file write enable (registered).
- `rd` out 5: register-file write address (registered).
- `w_data` out 32: register-file write data (registered).
- `grant_idx` out `$clog2(NUM_REQ)`: index of the last granted requester (registered).
- `contention_cnt` out `CNT_W`: count of cycles in which ≥1 valid requester was not granted; saturates.

## Operation
- Combinational arbitration each cycle:
  - If `dbg_wen`, then `req_ready = 0`.
  - Otherwise grant the first valid requester at or after `rr_ptr`, searching upward with wrap. Exactly one `req_ready` bit is set if any request is valid.
- `req_ready` depends only on `req_valid`, `dbg_wen` and `rr_ptr`; it never depends on `req_rd` or `req_data`.
- Requesters hold `req_valid`, `req_rd` and `req_data` stable until granted. Once valid is asserted it is not withdrawn before the grant.
- Pointer update on a requester grant at index g: `rr_ptr <= (g+1) mod NUM_REQ`. `rr_ptr` is unchanged on a debug write or an idle cycle.
- Output stage, registered every cycle:
  - Debug write: `wen <= (dbg_rd != 0)`, `rd <= dbg_rd`, `w_data <= dbg_data`.
  - Requester grant: `wen <= (req_rd[g] != 0)`, `rd <= req_rd[g]`, `w_data <= req_data[g]`, `grant_idx <= g`.
  - Neither: `wen <= 0`; `rd` and `w_data` hold their previous values.
- x0 write: the requester is still granted (ready=1) and the pointer still advances, but `wen` stays 0.
- Contention counter: increments when the number of valid requesters minus granted requesters is ≥1. Debug cycles count whenever any request is valid. The counter saturates at all-ones.
- Reset (`RST`=1 at a `CLK` edge):
  - `wen`, `rd`, `w_data`, `grant_idx`, `rr_ptr` and `contention_cnt` all go to 0.
  - `req_ready` is forced to 0 while `RST` is high.
  - A write already in the output register during the reset edge is discarded: `wen` is 0 in the following cycle.

## Timing
- Grant to register-file write: 1 cycle. Request presented and granted in cycle N means `wen`=1 in cycle N+1, and the register-file contents update at the end of N+1.
- Throughput: one write per cycle; there is no bubble between back-to-back grants.
- Worst-case wait for requester i with no debug traffic: `NUM_REQ-1` cycles.
- A debug pulse in cycle N stalls all requesters for cycle N only.
- No combinational path from any input to `wen`, `rd`, `w_data`, `grant_idx` or `contention_cnt`.

## Structure
- Add `rf_wb_req_t` (`rd` of type `regidx_t`, `data` of type `word_t`) and `regidx_t` (logic [4:0]) to `rv32i_types_pkg`. Use `word_t` for all data.
- One sub-module, `rr_arbiter`, parameterized by N. It is a pure function: inputs `req`, `ptr`; outputs one-hot `gnt` and encoded `gnt_idx`. It is reusable for memory-port arbitration.
- The top level owns `rr_ptr`, the output register and the counter.
- Provide an `rv32i_rf_wb_if` interface with `arb` and `rf` modports. The `rf` side drives the register file's `wen`/`rd`/`w_data`.

## Test plan
- **Reset:** hold `RST` 2 cycles with all `req_valid`=1. Required: `req_ready`=0, `wen`=0, `rr_ptr`=0. After release, requester 0 is granted first.
- **Full rotation:** all 4 requesters valid continuously with rd=1..4 and data=0xA0..0xA3. Required: grants 0,1,2,3,0 in consecutive cycles, each with `wen`=1 one cycle later and matching rd/data. `contention_cnt` increments every cycle.
- **Debug preemption:** `dbg_wen` with rd=5 and data=0xDEADBEEF while requesters 1 and 2 are valid. Required: no grant that cycle, `rr_ptr` unchanged. Next cycle: `wen`=1, rd=5. Requester 1 is granted next.
- **x0 write:** requester 2 alone with rd=0 and data=0x1234. Required: `req_ready[2]`=1, next-cycle `wen`=0, `rr_ptr`=3.
- **Sparse and saturation:** only requester 3 valid while `rr_ptr`=0. Required: immediate grant, `rr_ptr` wraps to 0. With `CNT_W`=4 and two requesters held valid for 20 cycles, `contention_cnt` stops at 15.
- **Reset mid-write:** assert `RST` in the same cycle a grant occurs. Required: `wen`=0 the next cycle and no register-file update.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types_pkg
// Description : Shared RV32I datapath types used by the writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regidx_t;

    typedef struct packed {
        regidx_t rd;
        word_t   data;
    } rf_wb_req_t;

    localparam regidx_t c_REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/rv32i_rf_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_wb_if
// Description : Register-file write port bundle between arbiter and RF.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_rf_wb_if;

    logic                        wen;
    rv32i_types_pkg::regidx_t    rd;
    rv32i_types_pkg::word_t      w_data;

    modport arb (output wen, output rd, output w_data);
    modport rf  (input  wen, input  rd, input  w_data);

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; first request at or after
//               ptr wins, searching upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    int w_pos;

    // Scan from the farthest slot back toward ptr so the nearest request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (req[w_pos]) begin
                gnt        = '0;
                gnt[w_pos] = 1'b1;
                gnt_idx    = IDX_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rf_wb_arbiter
// Description : Round-robin writeback arbiter for the integer register file
//               write port, with an absolute-priority debug/CSR write.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_rf_wb_arbiter
    import rv32i_types_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*5-1:0]        req_rd,
    input  logic [NUM_REQ*32-1:0]       req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        dbg_wen,
    input  logic [4:0]                  dbg_rd,
    input  logic [31:0]                 dbg_data,
    output logic                        wen,
    output logic [4:0]                  rd,
    output logic [31:0]                 w_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
    output logic [CNT_W-1:0]            contention_cnt
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any_gnt;
    logic               w_contention;
    rf_wb_req_t         w_req_arr [NUM_REQ];
    rf_wb_req_t         w_sel;

    logic               r_wen;
    regidx_t            r_rd;
    word_t              r_w_data;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [CNT_W-1:0]   r_cnt;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_req_arr[i].rd   = req_rd[i*5 +: 5];
            assign w_req_arr[i].data = req_data[i*32 +: 32];
        end
    endgenerate

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready    = (RST || dbg_wen) ? '0 : w_gnt;
    assign w_any_gnt    = |req_ready;
    assign w_sel        = w_req_arr[w_gnt_idx];
    // Any valid requester left unserved this cycle, debug stalls included.
    assign w_contention = |(req_valid & ~req_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr    <= '0;
            r_wen       <= 1'b0;
            r_rd        <= '0;
            r_w_data    <= '0;
            r_grant_idx <= '0;
            r_cnt       <= '0;
        end else begin
            if (dbg_wen) begin
                r_wen    <= (dbg_rd != c_REG_X0);
                r_rd     <= dbg_rd;
                r_w_data <= dbg_data;
            end else if (w_any_gnt) begin
                r_wen       <= (w_sel.rd != c_REG_X0);
                r_rd        <= w_sel.rd;
                r_w_data    <= w_sel.data;
                r_grant_idx <= w_gnt_idx;
                r_rr_ptr    <= (w_gnt_idx == c_LAST_IDX) ? '0 : w_gnt_idx + IDX_W'(1);
            end else begin
                r_wen <= 1'b0;
            end
            if (w_contention && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    rv32i_rf_wb_if u_wb_if ();

    assign u_wb_if.wen    = r_wen;
    assign u_wb_if.rd     = r_rd;
    assign u_wb_if.w_data = r_w_data;

    assign wen            = u_wb_if.wen;
    assign rd             = u_wb_if.rd;
    assign w_data         = u_wb_if.w_data;
    assign grant_idx      = r_grant_idx;
    assign contention_cnt = r_cnt;

endmodule
`default_nettype wire
